// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr read-modify-write initiator between execute and csregfile
module csr_access_unit #(
  parameter logic [11:0] NOWR_CSR_ADDR = 12'h7FF,
  parameter logic [4:0]  ZERO_RD       = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rd,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        resp_valid,
  output logic        resp_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] src_q;
  logic [4:0]  src_idx_q;
  logic [31:0] old_val_q;

  logic        accept;
  logic        write_en;
  logic        illegal;
  logic [31:0] new_val;

  // State register plus request latch; old value captured at the end of READ
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= 12'h000;
      rd_q      <= 5'd0;
      src_q     <= 32'h0;
      src_idx_q <= 5'd0;
      old_val_q <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= req_funct3[1:0];
        addr_q    <= req_csr_addr;
        rd_q      <= req_rd;
        src_q     <= req_funct3[2] ? {27'b0, req_rs1_idx} : req_rs1_data;
        src_idx_q <= req_rs1_idx;
      end
      if (state == READ) begin
        old_val_q <= csr_rdata;
      end
    end
  end

  // Read-modify-write arithmetic and legality, evaluated from the latched request
  always_comb begin
    new_val  = 32'h0;
    write_en = (op_q == OP_RW) || (src_idx_q != 5'd0);
    illegal  = (op_q == 2'b00) || ((addr_q[11:10] == 2'b11) && write_en);
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = old_val_q | src_q;
      OP_RC:   new_val = old_val_q & ~src_q;
      default: new_val = 32'h0;
    endcase
  end

  // Next-state and output decode; every output starts at its idle value
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    accept       = 1'b0;
    csr_raddr    = 12'h000;
    csr_waddr    = NOWR_CSR_ADDR;
    csr_wdata    = 32'h0;
    rd_waddr     = ZERO_RD;
    rd_wdata     = 32'h0;
    resp_valid   = 1'b0;
    resp_illegal = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        accept    = req_valid && req_ready;
        if (accept) begin
          state_next = READ;
        end
      end
      READ: begin
        csr_raddr  = addr_q;
        state_next = WRITE;
      end
      WRITE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
        if (illegal) begin
          resp_illegal = 1'b1;
        end else begin
          if (write_en) begin
            csr_waddr = addr_q;
            csr_wdata = new_val;
          end
          rd_waddr = rd_q;
          rd_wdata = old_val_q;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - randomized self-checking bench for csr_access_unit
module tb_csr_access_unit;

  localparam logic [11:0] NOWR = 12'h7FF;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC = 12'h341;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MVENDORID = 12'hF11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b0;
  logic [11:0] req_csr_addr = 12'h0;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic [31:0] req_rs1_data = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        resp_valid;
  logic        resp_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [11:0] addr_pool [0:6];

  csr_access_unit #(.NOWR_CSR_ADDR(NOWR), .ZERO_RD(5'd0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_csr_addr(req_csr_addr),
    .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data), .req_rd(req_rd),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .resp_valid(resp_valid), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  // csregfile stand-in: combinational read, write on the clock edge
  assign csr_rdata = csr_mem[csr_raddr];
  always @(posedge clk) begin
    if (csr_waddr != NOWR) csr_mem[csr_waddr] <= csr_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full access; expectations come from the architectural Zicsr rules on ref_mem
  task automatic access(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [4:0] idx, input logic [31:0] data, input logic [4:0] rd);
    logic [31:0] src, old_v, new_v;
    logic        we, ill;
    src   = f3[2] ? {27'b0, idx} : data;
    old_v = ref_mem[addr];
    we    = (f3[1:0] == 2'b01) || (idx != 5'd0);
    ill   = (f3[1:0] == 2'b00) || ((addr >= 12'hC00) && we);
    if (f3[1:0] == 2'b01)      new_v = src;
    else if (f3[1:0] == 2'b10) new_v = old_v | src;
    else                       new_v = old_v & ~src;

    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr;
    req_rs1_idx = idx; req_rs1_data = data; req_rd = rd;
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1_data = $urandom;
    check("read_raddr", {20'b0, csr_raddr}, {20'b0, addr});
    check("read_busy", {30'b0, req_ready, resp_valid}, 32'd0);
    @(negedge clk);
    check("wr_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("wr_illegal", {31'b0, resp_illegal}, {31'b0, ill});
    check("wr_waddr", {20'b0, csr_waddr}, {20'b0, (!ill && we) ? addr : NOWR});
    if (!ill && we) check("wr_wdata", csr_wdata, new_v);
    check("wr_rd_waddr", {27'b0, rd_waddr}, {27'b0, ill ? 5'd0 : rd});
    if (!ill) check("wr_rd_wdata", rd_wdata, old_v);
    if (!ill && we) ref_mem[addr] = new_v;
  endtask

  initial begin
    logic [6:0] ready_seen;
    int         pulses;
    addr_pool[0] = A_MSTATUS; addr_pool[1] = A_MEPC; addr_pool[2] = A_MSCRATCH;
    addr_pool[3] = A_MVENDORID; addr_pool[4] = 12'hC00; addr_pool[5] = 12'hB00;
    addr_pool[6] = 12'h305;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    for (int i = 0; i < 7; i++) begin
      csr_mem[addr_pool[i]] = $urandom;
      ref_mem[addr_pool[i]] = csr_mem[addr_pool[i]];
    end
    csr_mem[A_MEPC] = 32'h10;       ref_mem[A_MEPC] = 32'h10;
    csr_mem[A_MVENDORID] = 32'h5A5; ref_mem[A_MVENDORID] = 32'h5A5;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_raddr", {20'b0, csr_raddr}, 32'd0);
    check("rst_waddr", {20'b0, csr_waddr}, {20'b0, NOWR});
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_rd", {27'b0, rd_waddr}, 32'd0);
    check("rst_rd_wdata", rd_wdata, 32'd0);
    check("rst_resp", {30'b0, resp_valid, resp_illegal}, 32'd0);
    rst = 1'b0;
    #1 check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Directed scenarios
    access(3'b001, A_MEPC, 5'd7, 32'hC3, 5'd5);
    @(negedge clk);
    check("mepc_written", csr_mem[A_MEPC], 32'hC3);
    csr_mem[A_MSTATUS] = 32'hA0; ref_mem[A_MSTATUS] = 32'hA0;
    access(3'b010, A_MSTATUS, 5'd3, 32'h0A, 5'd6);
    @(negedge clk);
    check("mstatus_rs", csr_mem[A_MSTATUS], 32'hAA);
    access(3'b111, A_MSTATUS, 5'h0A, 32'hFFFF_FFFF, 5'd6);
    @(negedge clk);
    check("mstatus_rci", csr_mem[A_MSTATUS], 32'hA0);
    access(3'b010, A_MVENDORID, 5'd0, 32'hFFFF_FFFF, 5'd9);
    access(3'b001, A_MVENDORID, 5'd0, 32'h1234, 5'd9);
    @(negedge clk);
    check("vendorid_kept", csr_mem[A_MVENDORID], 32'h5A5);
    access(3'b100, A_MSCRATCH, 5'd4, 32'h1, 5'd2);
    access(3'b000, A_MSCRATCH, 5'd4, 32'h1, 5'd2);

    // Request held valid: accepts every third cycle only
    ready_seen = 7'b0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = (i < 7); req_funct3 = 3'b010; req_csr_addr = A_MSCRATCH;
      req_rs1_idx = 5'd0; req_rd = 5'd1;
      if (i < 7) ready_seen[i] = req_ready;
      if (resp_valid) pulses++;
    end
    req_valid = 1'b0;
    check("hold_accept_pattern", {25'b0, ready_seen}, 32'b1001001);
    check("hold_resp_pulses", pulses, 32'd3);

    // Reset during READ abandons the access
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = A_MSCRATCH;
    req_rs1_idx = 5'd1; req_rs1_data = 32'hDEAD; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_in_read", {20'b0, csr_raddr}, {20'b0, A_MSCRATCH});
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_waddr", {20'b0, csr_waddr}, {20'b0, NOWR});
    check("rstmid_rd", {27'b0, rd_waddr}, 32'd0);
    check("rstmid_resp", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1 check("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("rstmid_no_write", csr_mem[A_MSCRATCH], ref_mem[A_MSCRATCH]);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic [4:0] idx;
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      access(3'($urandom), addr_pool[$urandom_range(0, 6)], idx, $urandom, 5'($urandom));
    end
    @(negedge clk);
    for (int i = 0; i < 7; i++) check("final_mem", csr_mem[addr_pool[i]], ref_mem[addr_pool[i]]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR file read/write ports. It executes one Zicsr instruction per request: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI or CSRRCI.
- Per request it reads the CSR, computes the new value, writes it back, and returns the old value to rd through the GPR write port.
- Sits between the decode/execute stage and csregfile. The request/response handshake lets the pipeline stall while the access is in progress.

Parameters:
- NOWR_CSR_ADDR, `mdisable, CSR address driven on csr_waddr when no CSR write is intended.
- ZERO_RD, `ZERO_REG, rd address driven when no GPR write is intended.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset (`RST = 1)
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_funct3  in  3  [1:0]: 01=RW, 10=RS, 11=RC; [2]=immediate form
- req_csr_addr  in  12  target CSR
- req_rs1_idx  in  5  rs1 index, or uimm when funct3[2]=1
- req_rs1_data  in  32  rs1 value, ignored when funct3[2]=1
- req_rd  in  5  destination GPR
- csr_raddr  out  12  to csregfile
- csr_rdata  in  32  from csregfile, combinational read
- csr_waddr  out  12  to csregfile
- csr_wdata  out  32  to csregfile
- rd_waddr  out  5  to GPR write port
- rd_wdata  out  32  to GPR write port
- resp_valid  out  1  one-cycle completion pulse
- resp_illegal  out  1  qualifies resp_valid; access was illegal

Behaviour:
- States: IDLE, READ, WRITE. On reset, or from any state: state=IDLE and all latched fields cleared.
- Reset and IDLE output values:
  - csr_raddr=0, csr_waddr=NOWR_CSR_ADDR, csr_wdata=0
  - rd_waddr=ZERO_RD, rd_wdata=0
  - resp_valid=0, resp_illegal=0
  - req_ready=1 in IDLE and 0 in other states; req_ready=0 while rst=1.
- IDLE:
  - Accept when req_valid && req_ready. Latch funct3, CSR address, rd, and src.
  - src = funct3[2] ? {27'b0, req_rs1_idx} : req_rs1_data.
  - Next state is READ.
- READ, one cycle:
  - Drive csr_raddr = latched address.
  - Sample csr_rdata into old_val at the clock edge.
  - Next state is WRITE.
- WRITE, one cycle; resp_valid=1; next state IDLE.
  - new_val: RW → src; RS → old_val | src; RC → old_val & ~src.
  - write_en = (op==RW) || (src_field != 0), where src_field is the 5-bit rs1 index/uimm (not the rs1 data value).
  - If legal: csr_waddr = write_en ? address : NOWR_CSR_ADDR; csr_wdata = new_val (0 when not written).
  - If legal: rd_waddr = latched rd (x0 passes through harmlessly); rd_wdata = old_val.
- Illegal access, flagged in WRITE: funct3[1:0]==00, or (csr_addr[11:10]==2'b11 && write_en).
  - Response: resp_illegal=1; csr_waddr=NOWR_CSR_ADDR and rd_waddr=ZERO_RD (no side effects).
  - A read-only CSR with RS/RC and src_field=0 is legal: read only.
- Latency: request accepted at edge T, READ in cycle T+1, WRITE/resp_valid in cycle T+2. Next accept is no earlier than edge T+3.
- Throughput: one access per 3 cycles. Read and write of the same CSR never occur in the same cycle, so there is no bypass dependency on csregfile.
- Reset mid-operation, in READ or WRITE: abandon the access and return to IDLE with reset outputs. No CSR or GPR write is issued in the cycle after reset is sampled. A WRITE-cycle write already presented before reset is not retracted.
- req_valid while busy is ignored; the requester holds the request.
- Width rules:
  - All CSR data is 32-bit; uimm is zero-extended.
  - mcycle/mcycleh are treated as ordinary addresses, with the read-only check by address bits only.

Test Plan:
- Reset then CSRRW mepc, rs1_data=32'hC3, rd=5. csregfile mepc=32'h10 → cycle T+1 csr_raddr=mepc; cycle T+2 csr_waddr=mepc, csr_wdata=32'hC3, rd_waddr=5, rd_wdata=32'h10, resp_valid=1.
- CSRRS mstatus, rs1_idx=3, rs1_data=32'h0A, old=32'hA0 → csr_wdata=32'hAA, rd_wdata=32'hA0. CSRRCI mstatus, uimm=5'h0A, old=32'hAA → csr_wdata=32'hA0.
- CSRRS mvendorid (0xF11), rs1_idx=0 → legal read, csr_waddr=NOWR_CSR_ADDR, rd gets the vendor id, resp_illegal=0. Same with CSRRW → resp_illegal=1, csr_waddr=NOWR_CSR_ADDR, rd_waddr=0.
- funct3=3'b100 → resp_illegal=1, no writes; funct3=3'b000 → same.
- req_valid held high for 7 cycles → accepts at cycles 0, 3 and 6 only; req_ready low in between; exactly one resp_valid pulse per access.
- rst asserted during READ → next cycle IDLE, req_ready=1, csr_waddr=NOWR_CSR_ADDR, rd_waddr=0, no resp_valid.
